// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and one-at-a-time issue/response sequencer for an external combinational ALU
module alu_cmd_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [N-1:0]               cmd_a,
    input  logic [N-1:0]               cmd_b,
    input  logic [2:0]                 cmd_op,
    output logic [N-1:0]               alu_a,
    output logic [N-1:0]               alu_b,
    output logic [2:0]                 alu_opcode,
    input  logic [N-1:0]               alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N-1:0]               rsp_data,
    output logic                       rsp_illegal,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       busy,
    output logic [15:0]                ops_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    logic [N-1:0]    mem_a  [DEPTH];
    logic [N-1:0]    mem_b  [DEPTH];
    logic [2:0]      mem_op [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            not_empty;
    logic            push;
    logic            rsp_hs;
    logic            pop;

    assign full      = (fifo_level == LW'(DEPTH));
    assign not_empty = (fifo_level != '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign rsp_hs    = (state == RESP) && rsp_valid && rsp_ready;
    // A pop only ever happens when the next op can be loaded straight into ISSUE.
    assign pop       = not_empty && ((state == IDLE) || rsp_hs);
    assign busy      = (state != IDLE) || not_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= mem_a[rd_ptr];
                        alu_b      <= mem_b[rd_ptr];
                        alu_opcode <= mem_op[rd_ptr];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data    <= alu_result;
                    rsp_illegal <= alu_opcode[2];
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        ops_done  <= ops_done + 16'd1;
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= mem_a[rd_ptr];
                            alu_b      <= mem_b[rd_ptr];
                            alu_opcode <= mem_op[rd_ptr];
                            state      <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_illegal;
    logic [2:0]  fifo_level;
    logic        busy;
    logic [15:0] ops_done;

    int          checks;
    int          failures;
    int          hs_count;
    logic [15:0] exp_ops;
    logic [8:0]  exp_q[$];
    logic        held_valid;
    logic [8:0]  held_rsp;
    logic        rand_done;

    alu_cmd_sequencer #(.N(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal),
        .fifo_level(fifo_level), .busy(busy), .ops_done(ops_done)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            default: return 8'hFF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_opcode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Response monitor: scoreboard pop on handshake, stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else if (rsp_valid) begin
            if (held_valid) check("rsp_stable", {rsp_illegal, rsp_data}, held_rsp);
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("rsp_unexpected");
                end else begin
                    check("rsp_sb", {rsp_illegal, rsp_data}, exp_q.pop_front());
                end
                hs_count++;
                exp_ops    = exp_ops + 16'd1;
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_rsp   = {rsp_illegal, rsp_data};
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [7:0] exp_d);
        logic acc;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            if (acc) exp_q.push_back({op[2], exp_d});
            @(posedge clk);
            #1;
            if (acc) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        timeout_fail("push_timeout");
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) return;
        end
        timeout_fail(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        logic [7:0] ra, rb;
        logic [2:0] rop;
        checks = 0; failures = 0; hs_count = 0; exp_ops = '0;
        held_valid = 1'b0; held_rsp = '0; rand_done = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_alu_a", alu_a, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single add, latency
        rsp_ready = 1'b1;
        push_cmd(8'h05, 8'h03, 3'b000, 8'h08);
        check("lat_e0_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", rsp_valid, 0);
        check("lat_e1_alu_a", alu_a, 8'h05);
        check("lat_e1_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_e2_valid", rsp_valid, 1);
        check("lat_e2_data", rsp_data, 8'h08);
        check("lat_e2_illegal", rsp_illegal, 0);
        @(posedge clk); #1;
        check("t1_ops_done", ops_done, 1);
        check("t1_valid_low", rsp_valid, 0);
        wait_drain("t1_drain");

        // 2: fill the FIFO with responses blocked
        rsp_ready = 1'b0;
        push_cmd(8'h01, 8'h02, 3'd0, 8'h03);
        push_cmd(8'h09, 8'h04, 3'd1, 8'h05);
        push_cmd(8'h03, 8'h06, 3'd2, 8'h02);
        push_cmd(8'h07, 8'h07, 3'd3, 8'h00);
        check("t2_level3", fifo_level, 3);
        push_cmd(8'h10, 8'h20, 3'd0, 8'h30);
        check("t2_level4", fifo_level, 4);
        check("t2_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_a = 8'h40; cmd_b = 8'h02; cmd_op = 3'd0;
        repeat (5) @(posedge clk);
        #1;
        check("t2_stall_level", fifo_level, 4);
        check("t2_stall_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        push_cmd(8'h40, 8'h02, 3'd0, 8'h42);
        wait_drain("t2_drain");
        check("t2_ops_done", ops_done, exp_ops);

        // 3: back-to-back sub/and/xor
        push_cmd(8'h00, 8'h01, 3'd1, 8'hFF);
        push_cmd(8'hF0, 8'h3C, 3'd2, 8'h30);
        push_cmd(8'hAA, 8'hFF, 3'd3, 8'h55);
        wait_drain("t3_drain");

        // 4: illegal opcode
        push_cmd(8'h11, 8'h11, 3'b101, 8'hFF);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("t4_illegal", rsp_illegal, 1);
        check("t4_data", rsp_data, 8'hFF);
        wait_drain("t4_drain");

        // 5: async reset while in RESP with two entries queued
        rsp_ready = 1'b0;
        push_cmd(8'h01, 8'h01, 3'd0, 8'h02);
        push_cmd(8'h02, 8'h02, 3'd0, 8'h04);
        push_cmd(8'h03, 8'h03, 3'd0, 8'h06);
        check("t5_pre_valid", rsp_valid, 1);
        check("t5_pre_level", fifo_level, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_level", fifo_level, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_ops_done", ops_done, 0);
        check("t5_busy", busy, 0);
        exp_q.delete();
        exp_ops = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 6: 300 random ops with random response backpressure
        hs_before = hs_count;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    ra  = 8'($urandom);
                    rb  = 8'($urandom);
                    rop = 3'($urandom_range(0, 7));
                    push_cmd(ra, rb, rop, alu_f(ra, rb, rop));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain("t6_drain");
        check("t6_hs_count", hs_count - hs_before, 300);
        check("t6_ops_done", ops_done, exp_ops);

        // ops_done wrap from a preloaded value
        rsp_ready = 1'b0;
        force dut.ops_done = 16'hFFFE;
        #1;
        release dut.ops_done;
        exp_ops = 16'hFFFE;
        check("wrap_preload", ops_done, 16'hFFFE);
        rsp_ready = 1'b1;
        push_cmd(8'h21, 8'h01, 3'd1, 8'h20);
        push_cmd(8'h0F, 8'hF0, 3'd3, 8'hFF);
        push_cmd(8'h80, 8'h80, 3'd0, 8'h00);
        wait_drain("wrap_drain");
        check("wrap_ops_done", ops_done, 16'h0001);
        check("wrap_model", ops_done, exp_ops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
